// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends pat MSB-first reps times, optional parity bit (SEQ_GEN_TX_PARITY_EN) and GAP_LEN idle gap.
// Latency: first bit on OUT one cycle after start is accepted; done pulses the cycle after the last bit.
// Backpressure: none; start is ignored while a transmission is in progress, abort ends it the next cycle.
module seq_gen_tx #(
    parameter int   PAT_W    = 4,
    parameter int   REP_W    = 4,
    parameter int   GAP_LEN  = 0,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat,
    input  logic [REP_W-1:0] reps,
    output logic             OUT,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
`ifdef SEQ_GEN_TX_PARITY_EN
        PAR,
`endif
        GAP,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             rep_end;
    logic             out_d, valid_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            OUT     <= IDLE_LVL;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            OUT     <= out_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        pat_d   = pat_q;
        rep_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d   = pat;
                    rep_d   = reps;
                    idx_d   = IDX_LAST;
                    state_d = (reps == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (idx_q == '0) begin
`ifdef SEQ_GEN_TX_PARITY_EN
                    state_d = PAR;
`else
                    rep_end = 1'b1;
`endif
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
`ifdef SEQ_GEN_TX_PARITY_EN
            PAR: rep_end = 1'b1;
`endif
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = SEND;
                    idx_d   = IDX_LAST;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter holds repetitions still to send including the current one, so reps=max never wraps.
        if (rep_end) begin
            if (rep_q <= REP_W'(1)) begin
                state_d = FIN;
            end else begin
                rep_d = rep_q - REP_W'(1);
                if (GAP_LEN > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = SEND;
                    idx_d   = IDX_LAST;
                end
            end
        end

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end

        // Outputs are decoded from the next state so OUT/valid/busy/done come straight from flops.
        out_d   = IDLE_LVL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            SEND: begin
                out_d   = pat_d[idx_d];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`ifdef SEQ_GEN_TX_PARITY_EN
            PAR: begin
                out_d   = ^pat_d;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            GAP:     busy_d = 1'b1;
            FIN:     done_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: vector table plus scoreboard of per-cycle {OUT,valid,busy,done}, and hand sequences for abort/reset.
module tb_seq_gen_tx;

`ifdef SEQ_GEN_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, start0, start1, abort;
    logic [3:0] pat, reps;
    logic       out0, val0, busy0, done0;
    logic       out1, val1, busy1, done1;

    seq_gen_tx #(.PAT_W(4), .REP_W(4), .GAP_LEN(0), .IDLE_LVL(1'b0)) dut0 (
        .clk(clk), .res(res), .start(start0), .abort(abort), .pat(pat), .reps(reps),
        .OUT(out0), .valid(val0), .busy(busy0), .done(done0)
    );

    seq_gen_tx #(.PAT_W(4), .REP_W(4), .GAP_LEN(2), .IDLE_LVL(1'b0)) dut1 (
        .clk(clk), .res(res), .start(start1), .abort(abort), .pat(pat), .reps(reps),
        .OUT(out1), .valid(val1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [3:0] pat;
        logic [3:0] reps;
        bit         gap;        // 1: GAP_LEN=2 instance, 0: GAP_LEN=0 instance
        int         done_off;   // cycles from acceptance to done, without parity
        bit         poke_busy;  // extra start while busy
        bit         poke_fin;   // extra start during FIN
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb[$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {out,valid,busy,done}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] obs(input bit g);
        return g ? {out1, val1, busy1, done1} : {out0, val0, busy0, done0};
    endfunction

    task automatic push_expected(input vec_t v);
        for (int r = 0; r < int'(v.reps); r++) begin
            for (int b = 3; b >= 0; b--) sb.push_back({v.pat[b], 3'b110});
            if (PAR_EN != 0) sb.push_back({^v.pat, 3'b110});
            if (v.gap && r < int'(v.reps) - 1) begin
                sb.push_back(4'b0010);
                sb.push_back(4'b0010);
            end
        end
        sb.push_back(4'b0001);
        sb.push_back(4'b0000);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int k;
        int done_at;
        int exp_done;
        logic [3:0] e;
        logic [3:0] a;
        k = 0;
        done_at = -1;
        exp_done = v.done_off + PAR_EN * int'(v.reps);
        @(negedge clk);
        pat = v.pat;
        reps = v.reps;
        if (v.gap) start1 = 1'b1; else start0 = 1'b1;
        push_expected(v);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            a = obs(v.gap);
            chk($sformatf("%s_t+%0d", nm, k + 1), a, e);
            if (a[0] && done_at < 0) done_at = k + 1;
            start0 = 1'b0;
            start1 = 1'b0;
            if ((v.poke_busy && k == 1) || (v.poke_fin && k == exp_done - 1)) begin
                pat = ~v.pat;
                reps = 4'd1;
                if (v.gap) start1 = 1'b1; else start0 = 1'b1;
            end
            k++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        chk_int({nm, "_done_cycle"}, done_at, exp_done);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 4'd1,  1'b0, 5,  1'b0, 1'b0};
        vecs[1] = '{4'b1011, 4'd3,  1'b0, 13, 1'b1, 1'b0};
        vecs[2] = '{4'b1011, 4'd2,  1'b1, 11, 1'b0, 1'b0};
        vecs[3] = '{4'b1001, 4'd1,  1'b0, 5,  1'b0, 1'b1};
        vecs[4] = '{4'b0000, 4'd0,  1'b0, 1,  1'b0, 1'b1};
        vecs[5] = '{4'b1111, 4'd15, 1'b0, 61, 1'b0, 1'b0};
        vecs[6] = '{4'b0110, 4'd2,  1'b1, 11, 1'b1, 1'b0};
        vecs[7] = '{4'b1000, 4'd4,  1'b0, 17, 1'b0, 1'b0};

        res = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        pat = 4'b1111; reps = 4'd3;
        @(negedge clk);
        start0 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        chk("reset_dut0", obs(1'b0), 4'b0000);
        chk("reset_dut1", obs(1'b1), 4'b0000);
        start0 = 1'b0;
        start1 = 1'b0;
        res = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", obs(1'b0), 4'b0000);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort on the second bit of a two-repetition run.
        @(negedge clk);
        pat = 4'b1011; reps = 4'd2; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("abort_bit1", obs(1'b0), 4'b1110);
        @(negedge clk);
        chk("abort_bit2", obs(1'b0), 4'b0110);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", obs(1'b0), 4'b0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", i), obs(1'b0), 4'b0000);
        end

        // Abort together with start in IDLE: start must be dropped.
        @(negedge clk);
        pat = 4'b1111; reps = 4'd1; start0 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort = 1'b0;
        chk("abort_start_idle0", obs(1'b0), 4'b0000);
        @(negedge clk);
        chk("abort_start_idle1", obs(1'b0), 4'b0000);

        // Reset in the middle of SEND, then a fresh transmission.
        @(negedge clk);
        pat = 4'b1101; reps = 4'd3; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("res_mid_bit1", obs(1'b0), 4'b1110);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("res_mid_cleared", obs(1'b0), 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("res_mid_quiet%0d", i), obs(1'b0), 4'b0000);
        end
        run_vec(vecs[0], "after_res");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen_tx.md
SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern width in bits (2..16).
REQ-002 SHALL have parameter REP_W, default 4, width of the repetition count.
REQ-003 SHALL have parameter GAP_LEN, default 0, idle cycles inserted between repetitions (0..15).
REQ-004 SHALL have parameter IDLE_LVL, default 0, level of OUT when not transmitting.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port res, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1, request to begin a transmission.
REQ-008 SHALL have port abort, input, 1, terminate the transmission immediately.
REQ-009 SHALL have port pat, input, PAT_W, pattern to send, MSB first.
REQ-010 SHALL have port reps, input, REP_W, number of pattern repetitions.
REQ-011 SHALL have port OUT, output, 1, registered serial bit stream for a sequence detector INP.
REQ-012 SHALL have port valid, output, 1, high while OUT carries a pattern or parity bit.
REQ-013 SHALL have port busy, output, 1, high from accepted start until done or abort.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, PAR, GAP and FIN.
REQ-016 In IDLE, start=1 and abort=0 SHALL capture pat and reps into internal registers, assert busy next cycle and enter SEND, or FIN if reps==0.
REQ-017 start sampled while busy=1 SHALL be ignored; pat and reps SHALL be sampled only at acceptance.
REQ-018 SEND SHALL drive the captured pattern MSB first, one bit per cycle; the first bit appears on OUT the cycle after start is accepted, with valid=1.
REQ-019 After bit 0: go to PAR if parity is compiled in, else to GAP if GAP_LEN>0 and repetitions remain, else to SEND for the next repetition, else to FIN.
REQ-020 GAP SHALL hold OUT=IDLE_LVL and valid=0 for exactly GAP_LEN cycles; no gap SHALL follow the last repetition.
REQ-021 With GAP_LEN=0, consecutive repetitions SHALL be contiguous with no idle cycle.
REQ-022 The repetition counter SHALL be REP_W bits; reps at its maximum value SHALL send exactly that many repetitions without wrap.
REQ-023 FIN SHALL last one cycle with done=1, busy=0, valid=0 and OUT=IDLE_LVL, then return to IDLE; start in FIN SHALL be ignored.
REQ-024 abort=1 in any non-IDLE state SHALL next cycle enter IDLE with OUT=IDLE_LVL, valid=0, busy=0 and done=0.
REQ-025 abort and start both high in IDLE: abort wins and start SHALL be ignored.
REQ-026 Outside SEND/PAR, OUT SHALL equal IDLE_LVL and valid SHALL be 0.

Reset
REQ-027 res=1 at a clock edge SHALL force IDLE, OUT=IDLE_LVL, valid=0, busy=0, done=0 and clear all counters and captured registers.
REQ-028 res SHALL override start and abort, and reset mid-transmission SHALL abandon it without a done pulse.

Configuration
REQ-029 Macro SEQ_GEN_TX_PARITY_EN defined: PAR state SHALL send one even-parity bit (XOR of pattern bits) after each pattern, with valid=1.
REQ-030 Macro SEQ_GEN_TX_PARITY_EN undefined: PAR state and its logic SHALL be absent, and each repetition SHALL be exactly PAT_W bits.

Verification
REQ-031 PAT_W=4, pat=1011, reps=1, start at cycle t, no parity -> OUT=1,0,1,1 at t+1..t+4, valid high there, done at t+5, busy t+1..t+4.
REQ-032 pat=1011, reps=3, GAP_LEN=0 -> OUT stream 101110111011 contiguous, one done pulse after bit 12.
REQ-033 pat=1011, reps=2, GAP_LEN=2 -> 1011,idle,idle,1011 then done; no trailing gap.
REQ-034 SEQ_GEN_TX_PARITY_EN, pat=1011, reps=1 -> OUT=1,0,1,1,1 (parity 1), done at t+6; pat=1001 gives parity 0.
REQ-035 abort at 2nd bit of a reps=2 run -> IDLE next cycle, OUT=IDLE_LVL, no done; start during busy and reps=0 (done at t+1, no valid) also checked.
REQ-036 res asserted mid-SEND -> all outputs at reset values next cycle; a fresh start then transmits correctly.
